// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_gen
// Description : Programmable frame strobe with run/pause/step control,
//               divided sub-strobes, frame counter and ack/overrun tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
    parameter int CNT_W          = 21,
    parameter int DEFAULT_PERIOD = 1666667,
    parameter int NUM_CH         = 4,
    parameter int DIV_W          = 4,
    parameter int FRAME_W        = 16,
    parameter int OVR_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic                    period_ld,
    input  logic [CNT_W-1:0]        period_in,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    input  logic                    frame_ack,
    output logic                    tick,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [FRAME_W-1:0]      frame_cnt,
    output logic                    pending,
    output logic                    overrun,
    output logic [OVR_W-1:0]        ovr_cnt
);

    localparam logic [CNT_W-1:0] C_DEFAULT = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [OVR_W-1:0] C_OVR_MAX = '1;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period_act;
    logic [CNT_W-1:0]   r_shadow;
    logic               r_shadow_vld;
    logic               r_tick;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_pending;
    logic               r_overrun;
    logic [OVR_W-1:0]   r_ovr_cnt;

    logic [CNT_W-1:0]   w_p_eff;
    logic               w_wrap;
    logic               w_event;

    // Periods of 0 and 1 both mean a frame every cycle
    assign w_p_eff = (r_period_act > C_ONE) ? r_period_act : C_ONE;
    assign w_wrap  = run && (r_cnt == w_p_eff - C_ONE);
    assign w_event = w_wrap || (!run && step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_period_act <= C_DEFAULT;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_tick       <= 1'b0;
            r_frame_cnt  <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_ovr_cnt    <= '0;
        end else begin
            r_tick <= w_event;

            if (w_event) begin
                r_cnt <= '0;
            end else if (run) begin
                r_cnt <= r_cnt + C_ONE;
            end

            // New periods only take effect on a frame boundary
            if (w_event) begin
                r_shadow_vld <= 1'b0;
                if (period_ld) begin
                    r_period_act <= period_in;
                end else if (r_shadow_vld) begin
                    r_period_act <= r_shadow;
                end
            end else if (period_ld) begin
                r_shadow     <= period_in;
                r_shadow_vld <= 1'b1;
            end

            if (w_event) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                r_pending   <= 1'b1;
                if (r_pending && !frame_ack) begin
                    r_overrun <= 1'b1;
                    if (r_ovr_cnt != C_OVR_MAX) begin
                        r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
                    end
                end
            end else if (frame_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] w_div;
        logic [DIV_W:0]   w_inc;
        logic             w_hit;
        logic [DIV_W-1:0] r_ch_cnt;
        logic             r_ch_tick;

        assign w_div = ch_div[k*DIV_W +: DIV_W];
        assign w_inc = {1'b0, r_ch_cnt} + (DIV_W+1)'(1);
        // ">=" lets a freshly shrunk divisor wrap immediately
        assign w_hit = (w_div != '0) && (w_inc >= {1'b0, w_div});

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ch_cnt  <= '0;
                r_ch_tick <= 1'b0;
            end else begin
                r_ch_tick <= w_event && w_hit;
                if (w_event) begin
                    r_ch_cnt <= (w_hit || (w_div == '0)) ? '0 : w_inc[DIV_W-1:0];
                end
            end
        end

        assign ch_tick[k] = r_ch_tick;
    end

    assign tick      = r_tick;
    assign frame_cnt = r_frame_cnt;
    assign pending   = r_pending;
    assign overrun   = r_overrun;
    assign ovr_cnt   = r_ovr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_tick_gen
// Description : Directed self-checking bench for frame_tick_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tick_gen;

    localparam int CNT_W   = 21;
    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 4;
    localparam int FRAME_W = 16;
    localparam int OVR_W   = 8;
    localparam int LIMIT   = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    run;
    logic                    step;
    logic                    period_ld;
    logic [CNT_W-1:0]        period_in;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic                    frame_ack;
    logic                    tick;
    logic [NUM_CH-1:0]       ch_tick;
    logic [FRAME_W-1:0]      frame_cnt;
    logic                    pending;
    logic                    overrun;
    logic [OVR_W-1:0]        ovr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ch_seen [NUM_CH];

    frame_tick_gen #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (4),
        .NUM_CH         (NUM_CH),
        .DIV_W          (DIV_W),
        .FRAME_W        (FRAME_W),
        .OVR_W          (OVR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .period_ld (period_ld),
        .period_in (period_in),
        .ch_div    (ch_div),
        .frame_ack (frame_ack),
        .tick      (tick),
        .ch_tick   (ch_tick),
        .frame_cnt (frame_cnt),
        .pending   (pending),
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Edges until tick is seen; channel pulses are tallied along the way
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
            for (int k = 0; k < NUM_CH; k++) ch_seen[k] += int'(ch_tick[k]);
        end while (!tick && n < LIMIT);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tick"},      32'(tick),      0);
        check_eq({tag, "_ch_tick"},   32'(ch_tick),   0);
        check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check_eq({tag, "_pending"},   32'(pending),   0);
        check_eq({tag, "_overrun"},   32'(overrun),   0);
        check_eq({tag, "_ovr_cnt"},   32'(ovr_cnt),   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int quiet;
        for (int k = 0; k < NUM_CH; k++) ch_seen[k] = 0;
        rst = 1'b1; run = 1'b0; step = 1'b0; period_ld = 1'b0;
        period_in = '0; ch_div = '0; frame_ack = 1'b0;
        repeat (3) cyc();
        check_reset_outputs("reset");

        // Default period 4 for the first frame, loaded period 5 afterwards
        rst = 1'b0; run = 1'b1; period_ld = 1'b1; period_in = 5;
        ch_div = {4'd0, 4'd3, 4'd2, 4'd1};
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("first_gap", 32'(n + 1), 4);
        check_eq("frame_cnt_1", 32'(frame_cnt), 1);
        for (int i = 1; i < 12; i++) begin
            wait_tick(n);
            check_eq("gap5", 32'(n), 5);
            check_eq("frame_cnt_run", 32'(frame_cnt), 32'(i + 1));
        end
        check_eq("ch0_count", 32'(ch_seen[0]), 12);
        check_eq("ch1_count", 32'(ch_seen[1]), 6);
        check_eq("ch2_count", 32'(ch_seen[2]), 4);
        check_eq("ch3_count", 32'(ch_seen[3]), 0);
        check_eq("pending_noack", 32'(pending), 1);
        check_eq("overrun_noack", 32'(overrun), 1);
        check_eq("ovr_cnt_11", 32'(ovr_cnt), 11);

        // Pause with cnt=2, then resume: 3 edges remain in the frame
        cyc(); cyc();
        run = 1'b0;
        quiet = 0;
        repeat (20) begin
            cyc();
            quiet += int'(tick);
        end
        check_eq("pause_no_tick", 32'(quiet), 0);
        check_eq("pause_frame_cnt", 32'(frame_cnt), 12);
        run = 1'b1;
        wait_tick(n);
        check_eq("resume_gap", 32'(n), 3);
        check_eq("resume_frame_cnt", 32'(frame_cnt), 13);

        run = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            cyc();
            check_eq("step_tick", 32'(tick), 1);
            step = 1'b0;
            cyc();
            check_eq("step_after", 32'(tick), 0);
            cyc();
        end
        check_eq("step_frame_cnt", 32'(frame_cnt), 16);
        step = 1'b1;
        cyc();
        check_eq("b2b_step_1", 32'(tick), 1);
        cyc();
        check_eq("b2b_step_2", 32'(tick), 1);
        step = 1'b0;
        cyc();
        check_eq("b2b_step_end", 32'(tick), 0);
        check_eq("b2b_frame_cnt", 32'(frame_cnt), 18);

        run = 1'b1; step = 1'b1;
        cyc();
        check_eq("step_in_run", 32'(tick), 0);
        step = 1'b0;
        wait_tick(n);
        check_eq("step_in_run_gap", 32'(n), 4);
        check_eq("frame_cnt_19", 32'(frame_cnt), 19);

        // Period loads take effect only on frame boundaries
        period_ld = 1'b1; period_in = 4;
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("ld4_old_gap", 32'(n + 1), 5);
        wait_tick(n);
        check_eq("ld4_new_gap", 32'(n), 4);
        cyc(); cyc();
        period_ld = 1'b1; period_in = 8;
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("ld8_old_gap", 32'(n + 3), 4);
        wait_tick(n);
        check_eq("ld8_new_gap", 32'(n), 8);
        period_ld = 1'b1; period_in = 0;
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("ld0_old_gap", 32'(n + 1), 8);
        wait_tick(n);
        check_eq("p0_gap_a", 32'(n), 1);
        wait_tick(n);
        check_eq("p0_gap_b", 32'(n), 1);
        period_ld = 1'b1; period_in = 3;
        cyc();
        check_eq("ld_coincide_tick", 32'(tick), 1);
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("ld_coincide_gap", 32'(n), 3);
        check_eq("frame_cnt_28", 32'(frame_cnt), 28);

        // Overrun counter saturation at one tick per cycle
        period_ld = 1'b1; period_in = 0;
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("ld0_tail_gap", 32'(n), 2);
        repeat (300) cyc();
        check_eq("sat_tick", 32'(tick), 1);
        check_eq("sat_pending", 32'(pending), 1);
        check_eq("sat_overrun", 32'(overrun), 1);
        check_eq("sat_ovr_cnt", 32'(ovr_cnt), 255);
        check_eq("sat_frame_cnt", 32'(frame_cnt), 329);

        // Reset mid-frame with pending=1 and frame_cnt=7
        rst = 1'b1;
        cyc();
        rst = 1'b0; period_ld = 1'b1; period_in = 2;
        cyc();
        period_ld = 1'b0;
        wait_tick(n);
        check_eq("rst2_first_gap", 32'(n + 1), 4);
        for (int i = 0; i < 6; i++) begin
            wait_tick(n);
            check_eq("p2_gap", 32'(n), 2);
        end
        cyc();
        check_eq("pre_rst_frame_cnt", 32'(frame_cnt), 7);
        check_eq("pre_rst_pending", 32'(pending), 1);
        check_eq("pre_rst_ovr_cnt", 32'(ovr_cnt), 6);
        rst = 1'b1;
        cyc();
        check_reset_outputs("midrst");
        rst = 1'b0;
        wait_tick(n);
        check_eq("post_rst_gap", 32'(n), 4);
        check_eq("post_rst_pending", 32'(pending), 1);

        // Ack coincident with a frame event keeps pending without overrun
        frame_ack = 1'b1;
        wait_tick(n);
        check_eq("ack_gap", 32'(n), 4);
        frame_ack = 1'b0;
        check_eq("ack_coinc_pending", 32'(pending), 1);
        check_eq("ack_coinc_overrun", 32'(overrun), 0);
        check_eq("ack_coinc_ovr_cnt", 32'(ovr_cnt), 0);
        frame_ack = 1'b1;
        cyc();
        frame_ack = 1'b0;
        check_eq("ack_clears_pending", 32'(pending), 0);
        wait_tick(n);
        check_eq("acked_gap", 32'(n), 3);
        check_eq("acked_pending", 32'(pending), 1);
        check_eq("acked_ovr_cnt", 32'(ovr_cnt), 0);
        wait_tick(n);
        check_eq("late_ovr_cnt", 32'(ovr_cnt), 1);
        check_eq("late_overrun", 32'(overrun), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_tick_gen.md
Name: frame_tick_gen

Overview:
Parametrised frame-advance generator for the game pipeline. It produces a one-clock frame strobe at a runtime-programmable period and adds run/pause/single-step control. It also drives NUM_CH divided sub-strobes for slower game subsystems, a frame counter, and an ack handshake that flags frames the game logic failed to consume in time. It sits between the board clock and all game-state update logic.

Parameters:
CNT_W, 21, width of cycle counter and period register
DEFAULT_PERIOD, 1666667, reset period in clk cycles (60 Hz at 100 MHz)
NUM_CH, 4, number of divided sub-strobe channels
DIV_W, 4, width of each channel divisor
FRAME_W, 16, width of frame counter
OVR_W, 8, width of saturating overrun counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  level; 1 = free-running, 0 = paused
step  in  1  single-cycle pulse; one frame while paused
period_ld  in  1  load strobe for period_in
period_in  in  CNT_W  new period in cycles
ch_div  in  NUM_CH*DIV_W  per-channel divisor, channel k at bits [k*DIV_W +: DIV_W]
frame_ack  in  1  consumer finished the current frame
tick  out  1  frame strobe, one clk wide
ch_tick  out  NUM_CH  divided strobes, coincident with tick
frame_cnt  out  FRAME_W  frames issued since reset
pending  out  1  tick issued, not yet acked
overrun  out  1  sticky: a tick was issued while pending was still 1
ovr_cnt  out  OVR_W  number of overruns, saturating

Behaviour:
- Reset values: cnt=0, period_act=DEFAULT_PERIOD, shadow valid=0, tick=0, ch_tick=0, frame_cnt=0, pending=0, overrun=0, ovr_cnt=0, all channel counters=0. Reset mid-frame aborts the frame; tick is 0 in the cycle after the reset edge.
- P_eff = period_act, except values 0 and 1 are both treated as 1 (tick every cycle).
- Wrap condition: run=1 and cnt == P_eff-1.
- Run:
  - On wrap: cnt<=0 and a frame event fires; tick=1 for that one following cycle.
  - Otherwise: cnt<=cnt+1, tick=0.
  - Latency: the first tick is high after exactly P_eff rising edges with run=1 following reset release.
- Pause (run=0):
  - cnt holds and tick=0.
  - step=1 fires a frame event immediately (tick high the next cycle) and sets cnt<=0.
  - step while run=1 is ignored.
  - Back-to-back step pulses give back-to-back ticks.
- Period load:
  - period_ld captures period_in into a shadow register and sets shadow valid.
  - At the next frame event, period_act<=shadow and valid is cleared. The current frame is never truncated or stretched.
  - If period_ld coincides with a frame event, period_in is applied directly at that event.
  - A second load before the event overwrites the shadow.
- Frame event effects, all in the same clock:
  - frame_cnt increments, wrapping modulo 2^FRAME_W.
  - Channel k updates:
    - div_k=0: channel disabled; counter held at 0, ch_tick[k] never asserts.
    - Otherwise the counter increments. When it reaches div_k, it resets to 0 and ch_tick[k] is asserted together with tick.
    - div_k=1 asserts on every tick.
  - A change to div_k takes effect at the next event. A counter ≥ a newly smaller div_k resets to 0 and pulses.
- Handshake:
  - A frame event sets pending=1; frame_ack=1 clears it.
  - A frame event while pending=1 and no ack in the same cycle sets overrun=1 and increments ovr_cnt, saturating at 2^OVR_W-1.
  - An event and an ack in the same cycle: the old frame is acked, pending stays 1, and no overrun is counted.
  - overrun and ovr_cnt clear only on rst.
- All outputs are registered. tick and ch_tick are never high for two consecutive cycles, except when P_eff=1 or consecutive steps cause back-to-back frame events.

Test Plan:
1. Reset, run=1, period_ld period_in=5 at cycle 0 (applied at the first event, so the first frame uses DEFAULT_PERIOD). Override with a small DEFAULT_PERIOD=4 -> first tick after 4 edges, then tick every 5 cycles; frame_cnt 1,2,3…
2. DEFAULT_PERIOD=4, ch_div={4'd0,4'd3,4'd2,4'd1} -> ch_tick[0] on every tick, [1] on every 2nd, [2] on every 3rd, [3] never; over 12 ticks the counts are 12/6/4/0.
3. run=0 for 20 cycles -> no tick, cnt frozen. Three step pulses spaced 3 cycles apart -> exactly 3 ticks, each one cycle after its step; frame_cnt +3. Step with run=1 -> no extra tick.
4. Mid-frame period_ld period_in=8 while P=4 -> the current frame still ends after 4 cycles, the next gap is 8. period_in=0 -> tick every cycle.
5. frame_ack never driven, 300 ticks with OVR_W=8 -> pending=1, overrun=1, ovr_cnt saturates at 255. Ack coincident with a tick -> ovr_cnt unchanged.
6. rst asserted mid-count with pending=1 and frame_cnt=7 -> the next cycle shows all outputs at reset values, and period_act returns to DEFAULT_PERIOD.
